// File: rtl/sync_fifo_gen2_pkg.sv
// Shared types and default sizing for the gen2 single-clock FIFO.
package sync_fifo_gen2_pkg;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_DEPTH      = 8;

endpackage

// File: rtl/sync_fifo_gen2_mem.sv
// Storage array for the gen2 FIFO: one synchronous write port, one combinational read port.
module fifo_mem_dp #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int AW         = 3
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   // contents deliberately not reset; readers only see slots behind wr_ptr
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_gen2.sv
// Single-clock FIFO with configurable thresholds, optional first-word-fall-through and sync flush.
module sync_fifo_gen2
   import sync_fifo_gen2_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int AE_LEVEL   = 1,
   parameter int FWFT       = 0,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic [CNT_W-1:0]      count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

   if (!(AE_LEVEL > 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH - 1)) begin : g_bad_levels
      $error("sync_fifo_gen2: need 0 < AE_LEVEL < AF_LEVEL <= DEPTH-1");
   end

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  ack_q, ack_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  wr_acc;
   logic                  rd_acc;

   assign full   = (count_q == CNT_W'(DEPTH));
   assign empty  = (count_q == '0);
   assign wr_acc = wr_en && !full && !flush;
   assign rd_acc = rd_en && !empty && !flush;

   fifo_mem_dp #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      ack_d    = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         dout_d   = '0;
      end else begin
         ack_d = wr_acc;
         ovf_d = wr_en && full;
         udf_d = rd_en && empty;
         // explicit wrap so non-power-of-two depths work
         if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
         if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
         if (wr_acc && !rd_acc) count_d = count_q + CNT_W'(1);
         if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
         if (MODE == FIFO_STD && rd_acc) dout_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         ack_q    <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         ack_q    <= ack_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   assign data_out    = (MODE == FIFO_FWFT) ? (empty ? '0 : mem_rdata) : dout_q;
   assign wr_ack      = ack_q;
   assign overflow    = ovf_q;
   assign underflow   = udf_q;
   assign count       = count_q;
   assign almostfull  = (count_q >= CNT_W'(AF_LEVEL)) && !full;
   assign almostempty = (count_q <= CNT_W'(AE_LEVEL)) && !empty;

endmodule
